// File: rtl/scan_chain_pkg.sv
// Shared types and helpers for the scan chain controller.
// Holds the FSM state encoding and the bit-counter width function.
package scan_chain_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SHIFT   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_UNLOAD  = 3'd3,
    ST_FINISH  = 3'd4
  } state_e;

  localparam state_e RESET_STATE = ST_IDLE;

  // Bits needed to hold the values 0..n inclusive.
  function automatic int bit_cnt_w(input int n);
    int w;
    w = 1;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n + 1) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/scan_bit_counter.sv
// Loadable down-counter with enable; tc_o marks the final unit.
// Decrements never wrap below zero.
module scan_bit_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == W'(1));

endmodule

// File: rtl/scan_chain_ctrl.sv
// Scan session controller: shifts patterns in, captures, and
// streams responses out, overlapping unload with the next load.
module scan_chain_ctrl
  import scan_chain_pkg::*;
#(
  parameter int CHAIN_LEN = 64,
  parameter int PAT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [PAT_W-1:0] num_patterns,
  input  logic             abort,
  input  logic             pat_valid,
  output logic             pat_ready,
  input  logic             pat_bit,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_bit,
  output logic             Test_en,
  output logic             scan_in,
  input  logic             scan_out,
  output logic             chain_ce,
  output logic             busy,
  output logic             done
);

  localparam int CW = bit_cnt_w(CHAIN_LEN);
  localparam logic [CW-1:0] LEN = CW'(CHAIN_LEN);

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pat_cnt_q, pat_cnt_d;
  logic             first_q, first_d;
  logic             fire;
  logic             bc_load;
  logic [CW-1:0]    bc_val;
  logic             bc_tc;

  scan_bit_counter #(
    .W (CW)
  ) u_bit_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (bc_load),
    .load_val_i (bc_val),
    .en_i       (fire),
    .tc_o       (bc_tc)
  );

  assign resp_bit = scan_out;

  always_comb begin
    state_d    = state_q;
    pat_cnt_d  = pat_cnt_q;
    first_d    = first_q;
    bc_load    = 1'b0;
    bc_val     = LEN;
    fire       = 1'b0;
    Test_en    = 1'b0;
    chain_ce   = 1'b1;
    pat_ready  = 1'b0;
    resp_valid = 1'b0;
    scan_in    = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          if (num_patterns != '0) begin
            state_d   = ST_SHIFT;
            pat_cnt_d = num_patterns;
            first_d   = 1'b1;
            bc_load   = 1'b1;
          end else begin
            state_d = ST_FINISH;
          end
        end
      end
      ST_SHIFT: begin
        // First pattern has no prior capture to unload.
        Test_en    = 1'b1;
        pat_ready  = !abort && (resp_ready || first_q);
        resp_valid = !abort && pat_valid && !first_q;
        fire       = pat_valid && pat_ready;
        chain_ce   = fire;
        scan_in    = pat_bit;
        if (fire && bc_tc) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        first_d = 1'b0;
        bc_load = 1'b1;
        if (pat_cnt_q > PAT_W'(1)) begin
          state_d   = ST_SHIFT;
          pat_cnt_d = pat_cnt_q - PAT_W'(1);
        end else begin
          state_d   = ST_UNLOAD;
          pat_cnt_d = '0;
        end
      end
      ST_UNLOAD: begin
        Test_en    = 1'b1;
        resp_valid = !abort;
        fire       = resp_ready && !abort;
        chain_ce   = fire;
        if (fire && bc_tc) state_d = ST_FINISH;
      end
      ST_FINISH: begin
        done    = !abort;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort && state_q != ST_IDLE) begin
      state_d   = ST_IDLE;
      pat_cnt_d = '0;
      first_d   = 1'b0;
      bc_load   = 1'b1;
      bc_val    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RESET_STATE;
      pat_cnt_q <= '0;
      first_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_cnt_q <= pat_cnt_d;
      first_q   <= first_d;
    end
  end

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Scoreboard bench for scan_chain_ctrl on an 8-flop chain
// whose functional D input is the inverse of its Q.
module tb_scan_chain_ctrl;

  localparam int L = 8;
  localparam int PW = 16;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [PW-1:0] num_patterns;
  logic          abort;
  logic          pat_valid;
  logic          pat_ready;
  logic          pat_bit;
  logic          resp_valid;
  logic          resp_ready;
  logic          resp_bit;
  logic          Test_en;
  logic          scan_in;
  logic          scan_out;
  logic          chain_ce;
  logic          busy;
  logic          done;

  logic [L-1:0] chain = '0;

  int tests = 0;
  int fails = 0;
  int resp_cnt = 0;
  int cap_cnt = 0;
  int cyc = 0;
  logic exp_q[$];

  scan_chain_ctrl #(
    .CHAIN_LEN (L),
    .PAT_W     (PW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .num_patterns (num_patterns),
    .abort        (abort),
    .pat_valid    (pat_valid),
    .pat_ready    (pat_ready),
    .pat_bit      (pat_bit),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_bit     (resp_bit),
    .Test_en      (Test_en),
    .scan_in      (scan_in),
    .scan_out     (scan_out),
    .chain_ce     (chain_ce),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Chain of scan flops: shift in scan mode, D = ~Q otherwise.
  always @(posedge clk) begin
    if (chain_ce) begin
      if (Test_en) chain <= {chain[L-2:0], scan_in};
      else         chain <= ~chain;
    end
  end
  assign scan_out = chain[L-1];

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_rst_outs(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_te"}, int'(Test_en), 0);
    chk({tag, "_ce"}, int'(chain_ce), 1);
    chk({tag, "_prdy"}, int'(pat_ready), 0);
    chk({tag, "_rvld"}, int'(resp_valid), 0);
    chk({tag, "_si"}, int'(scan_in), 0);
  endtask

  // Response monitor: each response must be the inverse of the
  // stimulus bit accepted CHAIN_LEN fires earlier.
  always @(negedge clk) begin
    logic e;
    if (rst_n && resp_valid && resp_ready) begin
      tests++;
      resp_cnt++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL resp_extra: got %b expected none", resp_bit);
      end else begin
        e = exp_q.pop_front();
        if (resp_bit !== e) begin
          fails++;
          $display("FAIL resp_bit #%0d: got %b expected %b",
                   resp_cnt, resp_bit, e);
        end
      end
    end
    if (rst_n && busy && !Test_en && chain_ce && !done) cap_cnt++;
  end

  task automatic session(
    input  int         n,
    input  int         vp,
    input  int         rp,
    input  bit         fixd,
    input  logic [7:0] fpat,
    input  int         abort_at,
    input  int         stall_at,
    input  int         rst_at,
    output int         span
  );
    int acc, first_c, rbase, cbase, te_cnt;
    bit seen, ended, stalled;
    logic [L-1:0] snap;
    acc = 0; first_c = -1; span = 0;
    seen = 0; ended = 0; stalled = 0;
    rbase = resp_cnt; cbase = cap_cnt;
    @(posedge clk); #1;
    start = 1'b1;
    num_patterns = PW'(n);
    @(posedge clk); #1;
    start = 1'b0;
    for (int g = 0; g < 3000; g++) begin
      if (g == rst_at) begin
        chk("pre_rst_unload", int'(Test_en), 1);
        #3 rst_n = 1'b0;
        #1 chk_rst_outs("rst_mid");
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        pat_valid = 1'b0;
        exp_q.delete();
        te_cnt = 0;
        for (int k = 0; k < 6; k++) begin
          @(negedge clk);
          if (Test_en || busy) te_cnt++;
        end
        chk("post_rst_shifts", te_cnt, 0);
        ended = 1;
        break;
      end
      if (acc == abort_at) begin
        abort = 1'b1; pat_valid = 1'b1; resp_ready = 1'b1;
        @(negedge clk);
        chk("abort_ce", int'(chain_ce), 0);
        chk("abort_prdy", int'(pat_ready), 0);
        @(posedge clk); #1;
        abort = 1'b0; pat_valid = 1'b0;
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_te", int'(Test_en), 0);
        te_cnt = 0;
        for (int k = 0; k < 4; k++) begin
          if (done) te_cnt++;
          @(negedge clk);
        end
        chk("abort_no_done", te_cnt, 0);
        exp_q.delete();
        ended = 1;
        break;
      end
      if (acc == stall_at && !stalled) begin
        pat_valid = 1'b1; resp_ready = 1'b0;
        #1 snap = chain;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk("stall_ce", int'(chain_ce), 0);
          chk("stall_prdy", int'(pat_ready), 0);
          @(posedge clk); #1;
        end
        chk("stall_chain", int'(chain), int'(snap));
        stalled = 1;
      end
      pat_bit = fixd ? fpat[7 - (acc % 8)] : 1'($urandom);
      pat_valid = ($urandom_range(0, 99) < vp);
      resp_ready = ($urandom_range(0, 99) < rp);
      @(negedge clk);
      if (pat_valid && pat_ready) begin
        exp_q.push_back(!pat_bit);
        if (first_c < 0) first_c = cyc;
        acc++;
      end
      if (done) begin
        span = cyc - first_c + 1;
        seen = 1;
      end
      @(posedge clk); #1;
      if (seen) break;
    end
    pat_valid = 1'b0;
    resp_ready = 1'b1;
    if (!ended) begin
      chk("session_done", int'(seen), 1);
      chk("shift_bits", acc, n * L);
      chk("resp_bits", resp_cnt - rbase, n * L);
      chk("captures", cap_cnt - cbase, n);
      chk("queue_left", exp_q.size(), 0);
      @(negedge clk);
      chk("done_pulse", int'(done), 0);
      chk("busy_clear", int'(busy), 0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int span;
    rst_n = 1'b0; start = 1'b0; num_patterns = '0; abort = 1'b0;
    pat_valid = 1'b0; pat_bit = 1'b0; resp_ready = 1'b1;
    #3 chk_rst_outs("reset");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    session(1, 100, 100, 1, 8'b1011_0010, -1, -1, -1, span);
    chk("one_span", span, L + 1 + L + 1);

    session(3, 100, 100, 0, 8'h00, -1, -1, -1, span);
    chk("three_span", span, 3 * L + 3 + L + 1);

    session(2, 100, 100, 0, 8'h00, -1, 11, -1, span);

    @(posedge clk); #1;
    start = 1'b1; num_patterns = '0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("zero_done", int'(done), 1);
    chk("zero_te", int'(Test_en), 0);
    chk("zero_ce", int'(chain_ce), 1);
    @(negedge clk);
    chk("zero_done_end", int'(done), 0);

    session(2, 100, 100, 0, 8'h00, 3, -1, -1, span);
    session(2, 100, 100, 0, 8'h00, -1, -1, -1, span);
    chk("after_abort_span", span, 2 * L + 2 + L + 1);

    for (int r = 0; r < 6; r++) begin
      session(int'($urandom_range(1, 4)), 70, 70,
              0, 8'h00, -1, -1, -1, span);
    end

    session(1, 100, 100, 0, 8'h00, -1, -1, 11, span);
    session(2, 80, 80, 0, 8'h00, -1, -1, -1, span);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
